fir_tap_sequencer: RTL and testbench

Upstream feeder for the multiply-accumulate block. It accepts one input sample stream and stores the samples in an NTAPS-deep circular delay line, alongside a coefficient register file. For each accepted sample it transmits NTAPS (sample, coefficient) pairs on two AXI-stream master channels that connect directly to the MAC's A and B slave ports. A last flag marks the final tap of each output, so the downstream accumulator knows where each result ends.

---
 rtl/fir_tap_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//
// Feeds a multiply-accumulate block. Each accepted input sample is written to
// an NTAPS-deep circular delay line. The block then emits NTAPS
// (sample, coefficient) pairs, one per tap. For tap k, the A channel carries
// x(n-k) and the B channel carries c[k]. The A channel flags the last tap of
// each output.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   s_axis_t{data,valid,ready}
//                         input sample stream (slave)
//   coef_wr_{en,addr,data,ready}
//                         coefficient register-file write port; writes are
//                         accepted only while idle
//   m_axis_at{data,valid,ready,last}
//                         delayed-sample stream to MAC A (master)
//   m_axis_bt{data,valid,ready}
//                         coefficient stream to MAC B (master)
//   busy                  high while a tap sequence is being sent
//   state_dbg_o           current FSM state (0 = IDLE, 1 = SEND)
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid and ready are both high. A master never drops valid or changes
// data while valid=1 and ready=0. The A and B channels of one tap beat may
// transfer in different cycles. The beat is complete once both have
// transferred, and only then does the next tap appear.
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int  DW    = 24,
    parameter int  COEFW = 18,
    parameter int  NTAPS = 16,
    localparam int AW    = $clog2(NTAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             coef_wr_en,
    input  logic [AW-1:0]    coef_wr_addr,
    input  logic [COEFW-1:0] coef_wr_data,
    output logic             coef_wr_ready,
    output logic [DW-1:0]    m_axis_atdata,
    output logic             m_axis_atvalid,
    input  logic             m_axis_atready,
    output logic             m_axis_atlast,
    output logic [COEFW-1:0] m_axis_btdata,
    output logic             m_axis_btvalid,
    input  logic             m_axis_btready,
    output logic             busy,
    output logic             state_dbg_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
    localparam logic [AW:0]   NT   = (AW + 1)'(NTAPS);

    state_e           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    base_q, base_d;
    logic [AW-1:0]    k_q, k_d;
    logic             a_done_q, a_done_d;
    logic             b_done_q, b_done_d;
    logic [DW-1:0]    atdata_q, atdata_d;
    logic [COEFW-1:0] btdata_q, btdata_d;
    // Goes high on the first clock after reset release.
    // It holds off s_axis_tready and coef_wr_ready while reset is applied.
    logic             live_q;

    logic [DW-1:0]    delay_q [NTAPS];
    logic [COEFW-1:0] coef_q  [NTAPS];

    logic             in_idle;
    logic             in_send;
    logic             s_hs;
    logic             coef_we;
    logic             a_hs;
    logic             b_hs;
    logic             beat_done;
    logic [AW:0]      k_nx;
    logic [AW:0]      base_ext;
    logic [AW:0]      diff;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    k_nx_idx;

    assign in_idle = (state_q == S_IDLE);
    assign in_send = (state_q == S_SEND);

    assign s_axis_tready  = live_q & in_idle;
    assign coef_wr_ready  = live_q & in_idle;
    assign busy           = in_send;
    assign state_dbg_o    = state_q;
    assign m_axis_atvalid = in_send & ~a_done_q;
    assign m_axis_btvalid = in_send & ~b_done_q;
    assign m_axis_atlast  = in_send & (k_q == LAST);
    assign m_axis_atdata  = atdata_q;
    assign m_axis_btdata  = btdata_q;

    assign s_hs    = s_axis_tvalid & s_axis_tready;
    assign coef_we = coef_wr_en & coef_wr_ready & ({1'b0, coef_wr_addr} < NT);
    assign a_hs    = m_axis_atvalid & m_axis_atready;
    assign b_hs    = m_axis_btvalid & m_axis_btready;
    // A channel that has already transferred counts as done for this beat.
    assign beat_done = in_send & (a_hs | a_done_q) & (b_hs | b_done_q);

    // Delay-line address of the next tap: (base - (k+1)) mod NTAPS.
    // NTAPS need not be a power of two, so the wrap is explicit.
    always_comb begin
        k_nx     = {1'b0, k_q} + 1'b1;
        base_ext = {1'b0, base_q};
        if (base_ext >= k_nx) begin
            diff = base_ext - k_nx;
        end else begin
            diff = base_ext + NT - k_nx;
        end
        rd_idx   = diff[AW-1:0];
        k_nx_idx = (k_q == LAST) ? '0 : k_nx[AW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        base_d   = base_q;
        k_d      = k_q;
        a_done_d = a_done_q;
        b_done_d = b_done_q;
        atdata_d = atdata_q;
        btdata_d = btdata_q;
        case (state_q)
            S_IDLE: begin
                if (s_hs) begin
                    state_d  = S_SEND;
                    base_d   = wptr_q;
                    wptr_d   = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
                    k_d      = '0;
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    // Tap 0 is the sample arriving now, so bypass the delay line.
                    atdata_d = s_axis_tdata;
                    // A write to c[0] in the same cycle takes effect immediately.
                    btdata_d = (coef_we && coef_wr_addr == '0) ? coef_wr_data : coef_q[0];
                end
            end
            S_SEND: begin
                a_done_d = a_done_q | a_hs;
                b_done_d = b_done_q | b_hs;
                if (beat_done) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    if (k_q == LAST) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                    end else begin
                        k_d      = k_nx[AW-1:0];
                        atdata_d = delay_q[rd_idx];
                        btdata_d = coef_q[k_nx_idx];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            base_q   <= '0;
            k_q      <= '0;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            atdata_q <= '0;
            btdata_q <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            base_q   <= base_d;
            k_q      <= k_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
            atdata_q <= atdata_d;
            btdata_q <= btdata_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            if (s_hs) begin
                delay_q[wptr_q] <= s_axis_tdata;
            end
            if (coef_we) begin
                coef_q[coef_wr_addr] <= coef_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
//
// Bench for fir_tap_sequencer with NTAPS=4.
// The reference keeps the full history of accepted samples and a coefficient
// array. For every accepted sample it queues the NTAPS beats that must follow.
// The expected A data for tap k is the sample accepted k samples earlier, or 0
// if no such sample exists since reset.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

  localparam int DW = 24;
  localparam int CW = 18;
  localparam int NT = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          coef_wr_en = 1'b0;
  logic [AW-1:0] coef_wr_addr = '0;
  logic [CW-1:0] coef_wr_data = '0;
  logic          coef_wr_ready;
  logic [DW-1:0] atdata;
  logic          atvalid;
  logic          atready = 1'b0;
  logic          atlast;
  logic [CW-1:0] btdata;
  logic          btvalid;
  logic          btready = 1'b0;
  logic          busy;
  logic          state_dbg;

  fir_tap_sequencer #(.DW(DW), .COEFW(CW), .NTAPS(NT)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .coef_wr_en     (coef_wr_en),
    .coef_wr_addr   (coef_wr_addr),
    .coef_wr_data   (coef_wr_data),
    .coef_wr_ready  (coef_wr_ready),
    .m_axis_atdata  (atdata),
    .m_axis_atvalid (atvalid),
    .m_axis_atready (atready),
    .m_axis_atlast  (atlast),
    .m_axis_btdata  (btdata),
    .m_axis_btvalid (btvalid),
    .m_axis_btready (btready),
    .busy           (busy),
    .state_dbg_o    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // The input side goes live one clock after reset is released.
  logic armed;
  always @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_a_q[$];
  logic          exp_l_q[$];
  logic [CW-1:0] exp_b_q[$];
  logic [DW-1:0] hist[$];
  logic [CW-1:0] mcoef [NT];

  logic [DW-1:0] cap_a[$];
  logic          cap_l[$];
  logic [CW-1:0] cap_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic exp_av, exp_bv, exp_busy, exp_rdy;
  int   idx;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_atvalid", {31'b0, atvalid}, 0);
      chk("rst_btvalid", {31'b0, btvalid}, 0);
      chk("rst_tready",  {31'b0, s_tready}, 0);
      chk("rst_busy",    {31'b0, busy}, 0);
      chk("rst_atdata",  {8'b0, atdata}, 0);
      exp_a_q.delete();
      exp_l_q.delete();
      exp_b_q.delete();
      hist.delete();
      for (int i = 0; i < NT; i++) mcoef[i] = '0;
    end else begin
      exp_av   = (exp_a_q.size() > 0) && (exp_a_q.size() >= exp_b_q.size());
      exp_bv   = (exp_b_q.size() > 0) && (exp_b_q.size() >= exp_a_q.size());
      exp_busy = (exp_a_q.size() > 0) || (exp_b_q.size() > 0);
      exp_rdy  = armed && !exp_busy;
      chk("tready",    {31'b0, s_tready}, {31'b0, exp_rdy});
      chk("coef_rdy",  {31'b0, coef_wr_ready}, {31'b0, exp_rdy});
      chk("busy",      {31'b0, busy}, {31'b0, exp_busy});
      chk("atvalid",   {31'b0, atvalid}, {31'b0, exp_av});
      chk("btvalid",   {31'b0, btvalid}, {31'b0, exp_bv});
      if (exp_av) begin
        chk("atdata", {8'b0, atdata}, {8'b0, exp_a_q[0]});
        chk("atlast", {31'b0, atlast}, {31'b0, exp_l_q[0]});
        if (atready) begin
          cap_a.push_back(atdata);
          cap_l.push_back(atlast);
          void'(exp_a_q.pop_front());
          void'(exp_l_q.pop_front());
        end
      end
      if (exp_bv) begin
        chk("btdata", {14'b0, btdata}, {14'b0, exp_b_q[0]});
        if (btready) begin
          cap_b.push_back(btdata);
          void'(exp_b_q.pop_front());
        end
      end
      // A write and a sample accepted together: the write is seen by the new sequence.
      if (coef_wr_en && exp_rdy) mcoef[coef_wr_addr] = coef_wr_data;
      if (s_tvalid && exp_rdy) begin
        hist.push_back(s_tdata);
        for (int k = 0; k < NT; k++) begin
          idx = hist.size() - 1 - k;
          exp_a_q.push_back(idx >= 0 ? hist[idx] : '0);
          exp_l_q.push_back(k == NT - 1);
          exp_b_q.push_back(mcoef[k]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [DW-1:0] v);
    bit ok;
    ok = 1'b0;
    s_tdata  = v;
    s_tvalid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (s_tready) ok = 1'b1;
    end
    tick();
    s_tvalid = 1'b0;
    chk("send_timeout", {31'b0, ok}, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy && s_tready) ok = 1'b1;
    end
    tick();
    chk("idle_timeout", {31'b0, ok}, 1);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] d);
    wait_idle();
    coef_wr_en   = 1'b1;
    coef_wr_addr = a;
    coef_wr_data = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic clear_cap();
    cap_a.delete();
    cap_l.delete();
    cap_b.delete();
  endtask

  // ---------------- main sequence ----------------
  int exp_imp[16] = '{100, 0, 0, 0, 0, 100, 0, 0, 0, 0, 100, 0, 0, 0, 0, 100};
  int exp_wrap[4] = '{50, 40, 30, 20};
  bit found;

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      s_tvalid   = 1'($urandom_range(0, 1));
      s_tdata    = DW'($urandom);
      coef_wr_en = 1'($urandom_range(0, 1));
      atready    = 1'($urandom_range(0, 1));
      btready    = 1'($urandom_range(0, 1));
      tick();
    end
    s_tvalid = 1'b0; coef_wr_en = 1'b0;
    atready = 1'b1; btready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("tready_at_release", {31'b0, s_tready}, 0);
    tick();
    chk("tready_after_clock", {31'b0, s_tready}, 1);

    // Impulse response with coefficients 1,2,3,4.
    for (int i = 0; i < NT; i++) write_coef(AW'(i), CW'(i + 1));
    wait_idle();
    clear_cap();
    send_sample(24'd100); wait_idle();
    for (int i = 0; i < 3; i++) begin send_sample('0); wait_idle(); end
    chk("imp_count", cap_a.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("imp_a", {8'b0, cap_a[i]}, exp_imp[i]);
      chk("imp_b", {14'b0, cap_b[i]}, (i % 4) + 1);
      chk("imp_last", {31'b0, cap_l[i]}, {31'b0, (i % 4) == 3});
    end

    // Delay-line wrap.
    clear_cap();
    for (int i = 1; i <= 5; i++) begin send_sample(DW'(10 * i)); wait_idle(); end
    chk("wrap_count", cap_a.size(), 20);
    for (int i = 0; i < 4; i++) chk("wrap_a", {8'b0, cap_a[16 + i]}, exp_wrap[i]);

    // Skewed backpressure: B stalls while A is ready.
    clear_cap();
    atready = 1'b1; btready = 1'b0;
    send_sample(24'h800005);
    repeat (3) tick();
    btready = 1'b1;
    wait_idle();
    chk("skew_a_beats", cap_a.size(), 4);
    chk("skew_b_beats", cap_b.size(), 4);
    chk("skew_a0", {8'b0, cap_a[0]}, 32'h800005);

    // Coefficient write is ignored during SEND and taken in IDLE.
    clear_cap();
    atready = 1'b0; btready = 1'b0;
    send_sample(24'd1);
    coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_data = 18'h3FFF9;
    @(negedge clk);
    chk("coef_rdy_in_send", {31'b0, coef_wr_ready}, 0);
    tick();
    coef_wr_en = 1'b0;
    atready = 1'b1; btready = 1'b1;
    wait_idle();
    chk("coef_ignored", {14'b0, cap_b[0]}, 1);
    write_coef('0, 18'h3FFF9);
    clear_cap();
    send_sample(24'd2); wait_idle();
    chk("coef_taken", {14'b0, cap_b[0]}, 32'h3FFF9);

    // Reset in the middle of a sequence, while beat k=2 is presented.
    clear_cap();
    send_sample(24'd77);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (cap_a.size() == 2) found = 1'b1;
    end
    chk("midrst_reach_k2", {31'b0, found}, 1);
    rst = 1'b0;
    #1;
    chk("midrst_atvalid", {31'b0, atvalid}, 0);
    chk("midrst_btvalid", {31'b0, btvalid}, 0);
    chk("midrst_busy",    {31'b0, busy}, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_cap();
    send_sample(24'd55); wait_idle();
    chk("midrst_count", cap_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_a", {8'b0, cap_a[i]}, (i == 0) ? 55 : 0);
      chk("midrst_b", {14'b0, cap_b[i]}, 0);
    end

    // Randomized traffic, including writes that collide with sample accepts.
    for (int c = 0; c < 1500; c++) begin
      s_tvalid     = ($urandom_range(0, 2) == 0);
      s_tdata      = DW'($urandom);
      coef_wr_en   = ($urandom_range(0, 3) == 0);
      coef_wr_addr = AW'($urandom_range(0, NT - 1));
      coef_wr_data = CW'($urandom);
      atready      = ($urandom_range(0, 3) != 0);
      btready      = ($urandom_range(0, 2) != 0);
      tick();
    end
    s_tvalid = 1'b0; coef_wr_en = 1'b0;
    atready = 1'b1; btready = 1'b1;
    wait_idle();
    chk("leftover_a", exp_a_q.size(), 0);
    chk("leftover_b", exp_b_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
